// File: rtl/present_pkg.sv
// Shared types and constants for the PRESENT-80/128 round engine.
// Build option: define PRESENT_KEY128_EN for the 128-bit key schedule.
package present_pkg;

    localparam int BLOCK_W        = 64;
    localparam int RC_W           = 5;
    localparam int ROUNDS_DEFAULT = 31;

    localparam int KEY80_W   = 80;
    localparam int KEY128_W  = 128;
    localparam int RK80_LO   = KEY80_W - BLOCK_W;
    localparam int RK128_LO  = KEY128_W - BLOCK_W;

`ifdef PRESENT_KEY128_EN
    localparam int KEY_W = KEY128_W;
    localparam int RK_LO = RK128_LO;
`else
    localparam int KEY_W = KEY80_W;
    localparam int RK_LO = RK80_LO;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // (16*i) mod 63 on a 6-bit index is a left rotate by 4, and it also maps 63 to 63.
    function automatic logic [5:0] p_idx(input logic [5:0] i);
        return {i[1:0], i[5:2]};
    endfunction

endpackage

// File: rtl/present_key_sched.sv
// Combinational PRESENT key update upd(key, rc).
// PRESENT_KEY128_EN selects the 128-bit schedule; otherwise only the 80-bit path exists.
module present_key_sched
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [RC_W-1:0]  rc,
    output logic [KEY_W-1:0] key_next
);

    logic [KEY_W-1:0] rot;

    assign rot = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};

`ifdef PRESENT_KEY128_EN
    logic [3:0] sb_hi;
    logic [3:0] sb_lo;

    present_sbox u_sbox_hi (.din(rot[127:124]), .dout(sb_hi));
    present_sbox u_sbox_lo (.din(rot[123:120]), .dout(sb_lo));

    assign key_next = {sb_hi, sb_lo, rot[119:67], rot[66:62] ^ rc, rot[61:0]};
`else
    logic [3:0] sb_hi;

    present_sbox u_sbox_hi (.din(rot[79:76]), .dout(sb_hi));

    assign key_next = {sb_hi, rot[75:20], rot[19:15] ^ rc, rot[14:0]};
`endif

endmodule

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box (C56B90AD3EF84712), shared by datapath and key schedule.
module present_sbox (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = 4'h0;
        case (din)
            4'h0: dout = 4'hC;
            4'h1: dout = 4'h5;
            4'h2: dout = 4'h6;
            4'h3: dout = 4'hB;
            4'h4: dout = 4'h9;
            4'h5: dout = 4'h0;
            4'h6: dout = 4'hA;
            4'h7: dout = 4'hD;
            4'h8: dout = 4'h3;
            4'h9: dout = 4'hE;
            4'hA: dout = 4'hF;
            4'hB: dout = 4'h8;
            4'hC: dout = 4'h4;
            4'hD: dout = 4'h7;
            4'hE: dout = 4'h1;
            4'hF: dout = 4'h2;
            default: dout = 4'h0;
        endcase
    end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT encryption core: one round per clock, valid/ready in and out.
// Build option: PRESENT_KEY128_EN widens the key to 128 bits.
module present_round_engine
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_text,
    input  logic [KEY_W-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_text,
    output logic               busy
);

    if (ROUNDS < 1 || ROUNDS > (2 ** RC_W) - 1) begin : g_rounds_check
        $error("present_round_engine: ROUNDS must lie in 1..31");
    end

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] text_q, text_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [BLOCK_W-1:0] out_text_q, out_text_d;

    logic [BLOCK_W-1:0] ark;
    logic [BLOCK_W-1:0] s_out;
    logic [BLOCK_W-1:0] p_out;
    logic [KEY_W-1:0]   key_next;
    logic               last_round;

    assign ark        = text_q ^ key_q[KEY_W-1:RK_LO];
    assign last_round = (rc_q == RC_W'(ROUNDS));

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        present_sbox u_sbox (.din(ark[4*n +: 4]), .dout(s_out[4*n +: 4]));
    end

    always_comb begin
        p_out = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            p_out[p_idx(i[5:0])] = s_out[i[5:0]];
        end
    end

    present_key_sched u_key_sched (
        .key      (key_q),
        .rc       (rc_q),
        .key_next (key_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            text_q     <= '0;
            key_q      <= '0;
            rc_q       <= '0;
            out_text_q <= '0;
        end else begin
            state_q    <= state_d;
            text_q     <= text_d;
            key_q      <= key_d;
            rc_q       <= rc_d;
            out_text_q <= out_text_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_round) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The final round folds in K32 whitening so the result lands directly in out_text.
    always_comb begin
        text_d     = text_q;
        key_d      = key_q;
        rc_d       = rc_q;
        out_text_d = out_text_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    text_d = in_text;
                    key_d  = in_key;
                    rc_d   = RC_W'(1);
                end
            end
            ST_RUN: begin
                text_d = p_out;
                key_d  = key_next;
                if (last_round) begin
                    out_text_d = p_out ^ key_next[KEY_W-1:RK_LO];
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN);
        out_valid = (state_q == ST_DONE);
        out_text  = out_text_q;
    end

endmodule

// File: tb/tb_present_round_engine.sv
// Directed known-answer bench for present_round_engine (80-bit, or 128-bit with PRESENT_KEY128_EN).
module tb_present_round_engine;
    import present_pkg::*;

`ifdef PRESENT_KEY128_EN
    localparam int NKAT = 1;
`else
    localparam int NKAT = 4;
`endif
    localparam int EXP_LAT = 32;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_text;
    logic [KEY_W-1:0]   in_key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_text;
    logic               busy;

    logic [BLOCK_W-1:0] kat_pt  [NKAT];
    logic [KEY_W-1:0]   kat_key [NKAT];
    logic [BLOCK_W-1:0] kat_ct  [NKAT];

    int checks   = 0;
    int failures = 0;

    present_round_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block, returns edges from the accepting edge (counted as 1) until out_valid.
    task automatic applyStimulus(input logic [BLOCK_W-1:0] pt, input logic [KEY_W-1:0] key, output int lat);
        in_text  = pt;
        in_key   = key;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int idx;

`ifdef PRESENT_KEY128_EN
        kat_pt[0] = 64'h0; kat_key[0] = '0; kat_ct[0] = 64'h96DB702A2E6900AF;
`else
        kat_pt[0] = 64'h0;                kat_key[0] = '0; kat_ct[0] = 64'h5579C1387B228445;
        kat_pt[1] = 64'h0;                kat_key[1] = '1; kat_ct[1] = 64'hE72C46C0F5945049;
        kat_pt[2] = 64'hFFFFFFFFFFFFFFFF; kat_key[2] = '0; kat_ct[2] = 64'hA112FFC72F68417B;
        kat_pt[3] = 64'hFFFFFFFFFFFFFFFF; kat_key[3] = '1; kat_ct[3] = 64'h3333DCD3213210D2;
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_text   = '0;
        in_key    = '0;
        tick();
        tick();
        checkOutput("reset_in_ready",  128'(in_ready),  128'd1);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy",      128'(busy),      128'd0);
        checkOutput("reset_out_text",  128'(out_text),  128'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < NKAT; k++) begin
            applyStimulus(kat_pt[k], kat_key[k], lat);
            checkOutput($sformatf("kat%0d_latency", k), 128'(lat), 128'(EXP_LAT));
            checkOutput($sformatf("kat%0d_text", k), 128'(out_text), 128'(kat_ct[k]));
            if (k == 0) begin
                repeat (10) tick();
                checkOutput("bp_text_stable",  128'(out_text),  128'(kat_ct[0]));
                checkOutput("bp_valid_held",   128'(out_valid), 128'd1);
                checkOutput("bp_in_ready_low", 128'(in_ready),  128'd0);
                releaseResult();
                checkOutput("bp_release_valid", 128'(out_valid), 128'd0);
                checkOutput("bp_release_ready", 128'(in_ready),  128'd1);
            end else begin
                releaseResult();
            end
        end

        // Inputs wiggled during RUN must not disturb the accepted block.
        in_text  = kat_pt[0];
        in_key   = kat_key[0];
        in_valid = 1'b1;
        tick();
        checkOutput("ignore_busy",     128'(busy),     128'd1);
        checkOutput("ignore_in_ready", 128'(in_ready), 128'd0);
        for (int c = 0; c < 6; c++) begin
            in_text  = 64'hDEADBEEF00000000 | 64'(c);
            in_key   = ~in_key;
            in_valid = ~in_valid;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        checkOutput("ignore_text", 128'(out_text), 128'(kat_ct[0]));
        releaseResult();

        // Reset at rc=15: accepting edge sets rc=1, 14 more edges reach 15.
        idx = 1 % NKAT;
        in_text  = kat_pt[idx];
        in_key   = kat_key[idx];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_in_ready",  128'(in_ready),  128'd1);
        checkOutput("midrst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("midrst_out_text",  128'(out_text),  128'd0);
        checkOutput("midrst_busy",      128'(busy),      128'd0);
        applyStimulus(kat_pt[NKAT-1], kat_key[NKAT-1], lat);
        checkOutput("midrst_after_latency", 128'(lat), 128'(EXP_LAT));
        checkOutput("midrst_after_text", 128'(out_text), 128'(kat_ct[NKAT-1]));
        releaseResult();

        // Back-to-back: second block queued on in_valid while the first runs.
        idx = 2 % NKAT;
        out_ready = 1'b1;
        in_text   = kat_pt[0];
        in_key    = kat_key[0];
        in_valid  = 1'b1;
        tick();
        in_text = kat_pt[idx];
        in_key  = kat_key[idx];
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        checkOutput("b2b_first_text", 128'(out_text), 128'(kat_ct[0]));
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        checkOutput("b2b_accept_gap", 128'(n), 128'd2);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        checkOutput("b2b_second_text", 128'(out_text), 128'(kat_ct[idx]));
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_idle_after", 128'(in_ready), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/present_round_engine.md
Name: present_round_engine

Overview:
- Iterative PRESENT-80 block-cipher encryption core, one round per clock, sitting directly downstream of the 4-bit S-box stage.
- Each round applies addRoundKey, then sLayer (16 parallel S-boxes), then pLayer (bit permutation).
- Also hosts the key schedule, which uses its own S-box instance.
- Fed by the wrapper's register bank over a valid/ready handshake; returns the ciphertext over a second valid/ready handshake.

Parameters:
- ROUNDS, 31, number of full rounds before final whitening; reduced values are for debug only.
- KEY_W, 80, key width; 128 when PRESENT_KEY128_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  engine idle, can accept.
- in_text  input  64  plaintext block.
- in_key  input  KEY_W  cipher key.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_text  output  64  ciphertext.
- busy  output  1  high in RUN state.

Behaviour:
- FSM states are IDLE, RUN and DONE. Reset (synchronous, any state, including mid-RUN) forces:
  - state to IDLE;
  - in_ready=1, out_valid=0, busy=0;
  - out_text=0, state/key/round registers to 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=in_text, key_reg<=in_key, rc<=1, go to RUN.
- RUN:
  - in_ready=0, busy=1. Inputs are ignored.
  - Each cycle: state_reg <= P(S(state_reg ^ key_reg[KEY_W-1:KEY_W-64])).
  - Each cycle: key_reg <= upd(key_reg, rc), then rc<=rc+1.
  - rc is 5 bits.
- S: 16 nibble substitutions with the PRESENT S-box C56B90AD3EF84712 (nibble i uses bits 4i+3:4i).
- P: bit i moves to position (16*i) mod 63 for i=0..62; bit 63 stays at 63.
- upd for 80-bit keys:
  - rotate left by 61;
  - S-box on bits [79:76];
  - bits [19:15] ^= rc.
- Final RUN cycle (rc==ROUNDS):
  - out_text <= next_state ^ next_key[KEY_W-1:KEY_W-64] (whitening with K32);
  - out_valid<=1, go to DONE.
- Latency: out_valid rises exactly ROUNDS+1 = 32 clocks after the accepting edge.
- DONE:
  - out_valid=1; out_text is held stable until out_ready.
  - On out_ready: out_valid<=0, go to IDLE. in_ready returns 1 on the following cycle.
  - A new block cannot be accepted in the same cycle the result is taken.
- out_ready asserted while not DONE has no effect.
- in_valid held high across DONE→IDLE: the block is accepted on the first IDLE cycle.
- rc never wraps: ROUNDS ≤ 31 is enforced by an elaboration-time check.

Optional Feature:
- Macro: PRESENT_KEY128_EN.
- Defined:
  - KEY_W=128;
  - upd rotates left by 61;
  - S-box on [127:124] and [123:120];
  - bits [66:62] ^= rc;
  - round key is key_reg[127:64].
- Undefined: 80-bit key path only, with no 128-bit logic synthesized.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package present_pkg holds:
  - FSM state enum;
  - ROUNDS default, block width 64, round-counter width 5;
  - pLayer index function;
  - round-key slice constants for 80 and 128 bits.
- The S-box is instantiated 16× in the datapath from the existing 4-bit sbox module, not duplicated as a table.
- One natural sub-module, present_key_sched: combinational upd(key, rc) containing its own S-box instance(s), selected by PRESENT_KEY128_EN.

Test Plan:
- Known-answer vectors (80-bit build):
  - pt=0000000000000000, key=0 → out_text=5579C1387B228445;
  - pt=0, key=FFFFFFFFFFFFFFFFFFFF → E72C46C0F5945049;
  - pt=FFFFFFFFFFFFFFFF, key=0 → A112FFC72F68417B;
  - pt=FFFF…, key=FFFF… → 3333DCD3213210D2.
  - In each case out_valid rises exactly 32 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_text and out_valid remain stable, in_ready=0; pulse out_ready → IDLE next cycle.
- Busy-ignore: in RUN, change in_text/in_key and toggle in_valid → result still equals the vector of the originally accepted block.
- Mid-operation reset: assert rst at rc=15 → next cycle IDLE, in_ready=1, out_valid=0, out_text=0; the following new block encrypts correctly.
- Back-to-back: in_valid held high with two blocks queued and out_ready=1 → second accept occurs 2 cycles after the first out_valid; both ciphertexts correct.
- PRESENT_KEY128_EN build: pt=0, key=0 (128-bit) → out_text=96DB702A2E6900AF with the same 32-cycle latency.
